my_gpio_unit: RTL and testbench

MY_GPIO_UNIT -- requirements
Module: my_gpio_unit

---
 rtl/my_gpio_unit.sv | 106 ++++++++++
 tb/tb_my_gpio_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_gpio_unit.sv
// GPIO unit: CPU-writable LED register, synchronised and debounced switches and push-button,
// and a one-cycle trap release pulse per accepted press. Debounce counters exist only with MY_GPIO_DEBOUNCE_EN.
module my_gpio_unit #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gpio_ctrl_write,
  input  logic [DATA_WIDTH-1:0] gpio_data_out,
  output logic [DATA_WIDTH-1:0] gpio_data_in,
  output logic                  trap_trigger,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  button_n,
  output logic [DATA_WIDTH-1:0] led
);

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (1 << 20))) begin : g_bad_debounce_cycles
    $error("my_gpio_unit: DEBOUNCE_CYCLES must lie in 2 .. 2**20");
  end

  logic [DATA_WIDTH-1:0] r_led;
  logic [DATA_WIDTH-1:0] r_sw_s1, r_sw_s2, r_sw_stable, w_sw_stable_nxt;
  logic                  r_btn_s1, r_btn_s2, r_btn_stable, w_btn_stable_nxt;
  logic                  r_trap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (gpio_ctrl_write) begin
      r_led <= gpio_data_out;
    end
  end

  // The button is inverted before synchronising, so the reset value 0 means "released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= ~button_n;
      r_btn_s2 <= r_btn_s1;
    end
  end

`ifdef MY_GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_sw_cnt, w_sw_cnt_nxt;
  logic [CNT_W-1:0] r_btn_cnt, w_btn_cnt_nxt;

  // The count is not restarted by a new non-stable value; whatever s2 holds at the commit edge wins.
  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    w_sw_stable_nxt  = r_sw_stable;
    w_sw_cnt_nxt     = '0;
    w_btn_stable_nxt = r_btn_stable;
    w_btn_cnt_nxt    = '0;
    if (r_sw_s2 != r_sw_stable) begin
      if (r_sw_cnt == CNT_MAX) w_sw_stable_nxt = r_sw_s2;
      else                     w_sw_cnt_nxt    = r_sw_cnt + CNT_W'(1);
    end
    if (r_btn_s2 != r_btn_stable) begin
      if (r_btn_cnt == CNT_MAX) w_btn_stable_nxt = r_btn_s2;
      else                      w_btn_cnt_nxt    = r_btn_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_cnt  <= '0;
      r_btn_cnt <= '0;
    end else begin
      r_sw_cnt  <= w_sw_cnt_nxt;
      r_btn_cnt <= w_btn_cnt_nxt;
    end
  end
`else
  assign w_sw_stable_nxt  = r_sw_s2;
  assign w_btn_stable_nxt = r_btn_s2;
`endif

  // The pulse is raised on the same edge that the button stable register rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_stable  <= '0;
      r_btn_stable <= 1'b0;
      r_trap       <= 1'b0;
    end else begin
      r_sw_stable  <= w_sw_stable_nxt;
      r_btn_stable <= w_btn_stable_nxt;
      r_trap       <= w_btn_stable_nxt & ~r_btn_stable;
    end
  end

  assign led          = r_led;
  assign gpio_data_in = r_sw_stable;
  assign trap_trigger = r_trap;

endmodule

// File: tb/tb_my_gpio_unit.sv
// Directed bench for my_gpio_unit with DEBOUNCE_CYCLES=4; expected latency follows MY_GPIO_DEBOUNCE_EN.
module tb_my_gpio_unit;

  localparam int DW = 8;
  localparam int DC = 4;
`ifdef MY_GPIO_DEBOUNCE_EN
  localparam int LAT = DC + 2;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          gpio_ctrl_write;
  logic [DW-1:0] gpio_data_out;
  logic [DW-1:0] gpio_data_in;
  logic          trap_trigger;
  logic [DW-1:0] sw;
  logic          button_n;
  logic [DW-1:0] led;

  int checks = 0;
  int errors = 0;

  my_gpio_unit #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk             (clk),
    .rst             (rst),
    .gpio_ctrl_write (gpio_ctrl_write),
    .gpio_data_out   (gpio_data_out),
    .gpio_data_in    (gpio_data_in),
    .trap_trigger    (trap_trigger),
    .sw              (sw),
    .button_n        (button_n),
    .led             (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_switches();
    sw = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    checks++;
    if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in: got %h want 00", gpio_data_in); end
    checks++;
    if (trap_trigger !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trap_trigger); end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (trap_trigger !== 1'b0 || gpio_data_in !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle: trap %b data_in %h want 0/00", trap_trigger, gpio_data_in);
    end
  endtask

  task automatic test_led_write();
    gpio_ctrl_write = 1'b1;
    gpio_data_out   = 8'hA5;
    tick();
    gpio_ctrl_write = 1'b0;
    gpio_data_out   = 8'h3C;
    checks++;
    if (led !== 8'hA5) begin errors++; $display("FAIL led_write: got %h want a5", led); end
    repeat (3) tick();
    checks++;
    if (led !== 8'hA5) begin errors++; $display("FAIL led_hold: got %h want a5", led); end
    checks++;
    if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL led_no_sw_effect: got %h want 00", gpio_data_in); end
    gpio_ctrl_write = 1'b1;
    gpio_data_out   = 8'h5A;
    rst             = 1'b1;
    tick();
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL led_rst_priority: got %h want 00", led); end
    rst             = 1'b0;
    gpio_ctrl_write = 1'b0;
    tick();
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL led_write_lost: got %h want 00", led); end
  endtask

  task automatic test_switch_accept();
    logic [DW-1:0] exp;
    sw = 8'h3C;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      exp = (e >= LAT) ? 8'h3C : 8'h00;
      checks++;
      if (gpio_data_in !== exp) begin
        errors++; $display("FAIL switch_accept edge %0d: got %h want %h", e, gpio_data_in, exp);
      end
    end
    repeat (3) tick();
    checks++;
    if (gpio_data_in !== 8'h3C) begin errors++; $display("FAIL switch_hold: got %h want 3c", gpio_data_in); end
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL switch_no_led_effect: got %h want 00", led); end
    settle_switches();
    checks++;
    if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL switch_release: got %h want 00", gpio_data_in); end
  endtask

  task automatic test_bounce_reject();
    for (int k = 0; k < 4; k++) begin
      sw = (k % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) begin
        tick();
        checks++;
        if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL bounce_reject: got %h want 00", gpio_data_in); end
      end
    end
    settle_switches();
    checks++;
    if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL bounce_settle: got %h want 00", gpio_data_in); end
  endtask

  task automatic test_midcount_change();
    logic [DW-1:0] exp;
    sw = 8'h01;
    tick();
    tick();
    sw = 8'h02;
    for (int e = 3; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 8'h02 : 8'h00;
      checks++;
      if (gpio_data_in !== exp) begin
        errors++; $display("FAIL midcount_change edge %0d: got %h want %h", e, gpio_data_in, exp);
      end
    end
    settle_switches();
  endtask

  task automatic test_button();
    int pulses = 0;
    int first  = 0;
    button_n = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (trap_trigger === 1'b1) begin
        pulses++;
        if (first == 0) first = e;
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL button_pulse_count: got %0d want 1", pulses); end
    checks++;
    if (first !== LAT) begin errors++; $display("FAIL button_pulse_edge: got %0d want %0d", first, LAT); end
    button_n = 1'b1;
    pulses   = 0;
    repeat (20) begin
      tick();
      if (trap_trigger !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL button_release_pulse: got %0d want 0", pulses); end
    checks++;
    if (gpio_data_in !== 8'h00 || led !== 8'h00) begin
      errors++; $display("FAIL button_isolation: data_in %h led %h want 00/00", gpio_data_in, led);
    end
  endtask

  task automatic test_short_press();
    int pulses = 0;
    int exp    = DEB ? 0 : 1;
    button_n = 1'b0;
    tick();
    button_n = 1'b1;
    repeat (15) begin
      tick();
      if (trap_trigger === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== exp) begin errors++; $display("FAIL short_press: got %0d pulses want %0d", pulses, exp); end
  endtask

  task automatic test_reset_midcount();
    logic [DW-1:0] exp;
    sw = 8'hFF;
    for (int e = 1; e <= 3; e++) begin
      tick();
      exp = (e >= LAT) ? 8'hFF : 8'h00;
      checks++;
      if (gpio_data_in !== exp) begin
        errors++; $display("FAIL rst_midcount_pre edge %0d: got %h want %h", e, gpio_data_in, exp);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gpio_data_in !== 8'h00) begin errors++; $display("FAIL rst_midcount_clear: got %h want 00", gpio_data_in); end
    rst = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      exp = (e >= LAT) ? 8'hFF : 8'h00;
      checks++;
      if (gpio_data_in !== exp) begin
        errors++; $display("FAIL rst_midcount_post edge %0d: got %h want %h", e, gpio_data_in, exp);
      end
    end
    settle_switches();
  endtask

  task automatic test_held_through_reset();
    int pulses = 0;
    int first  = 0;
    logic [DW-1:0] exp;
    rst      = 1'b1;
    sw       = 8'h42;
    button_n = 1'b0;
    tick();
    tick();
    checks++;
    if (gpio_data_in !== 8'h00 || trap_trigger !== 1'b0) begin
      errors++; $display("FAIL held_in_reset: data_in %h trap %b want 00/0", gpio_data_in, trap_trigger);
    end
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (trap_trigger === 1'b1) begin
        pulses++;
        if (first == 0) first = e;
      end
      if (e == LAT - 1 || e == LAT) begin
        exp = (e == LAT) ? 8'h42 : 8'h00;
        checks++;
        if (gpio_data_in !== exp) begin
          errors++; $display("FAIL held_sw edge %0d: got %h want %h", e, gpio_data_in, exp);
        end
      end
    end
    checks++;
    if (pulses !== 1 || first !== LAT) begin
      errors++; $display("FAIL held_button: got %0d pulses at edge %0d want 1 at %0d", pulses, first, LAT);
    end
    button_n = 1'b1;
    settle_switches();
  endtask

  initial begin
    rst             = 1'b1;
    gpio_ctrl_write = 1'b0;
    gpio_data_out   = '0;
    sw              = '0;
    button_n        = 1'b1;
    test_reset();
    test_led_write();
    test_switch_accept();
    if (DEB) begin
      test_bounce_reject();
      test_midcount_change();
    end
    test_button();
    test_short_press();
    test_reset_midcount();
    test_held_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
